// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty flags, sticky overflow/underflow
// flags and a read-data valid strobe.
//
// Optional feature macro: FIFO_FWFT_EN
//   undefined : registered read, rd_data/rd_valid update on the edge after rd_en
//   defined   : first-word-fall-through, head word shown whenever not empty
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   wr_en        write request
//   wr_data      write data word
//   rd_en        read request
//   rd_data      read data word
//   rd_valid     rd_data carries a newly popped word (FWFT: head is valid)
//   empty        count == 0
//   full         count == DEPTH
//   almost_empty count <= AEMPTY_THRESH
//   almost_full  count >= AFULL_THRESH
//   count        occupancy, 0..DEPTH
//   overflow     sticky: a write was dropped
//   underflow    sticky: a read was refused
//   clr_err      synchronous clear of overflow/underflow
module fifo_sync_param #(
    parameter int unsigned N_ADDR_BITS   = 2,
    parameter int unsigned FIFO_WIDTH    = 8,
    parameter int unsigned AFULL_THRESH  = (1 << N_ADDR_BITS) - 1,
    parameter int unsigned AEMPTY_THRESH = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [FIFO_WIDTH-1:0]  wr_data,
    input  logic                   rd_en,
    output logic [FIFO_WIDTH-1:0]  rd_data,
    output logic                   rd_valid,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_empty,
    output logic                   almost_full,
    output logic [N_ADDR_BITS:0]   count,
    output logic                   overflow,
    output logic                   underflow,
    input  logic                   clr_err
);

    localparam int unsigned DEPTH = 1 << N_ADDR_BITS;
    localparam int unsigned CW    = N_ADDR_BITS + 1;

    localparam logic [CW-1:0]          DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]          AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0]          AEMPTY_C = CW'(AEMPTY_THRESH);
    localparam logic [CW-1:0]          CNT_ONE  = CW'(1);
    localparam logic [N_ADDR_BITS-1:0] PTR_ONE  = N_ADDR_BITS'(1);

    logic [FIFO_WIDTH-1:0]  mem_q [DEPTH];

    logic [N_ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [N_ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q,  count_d;
    logic                   ovf_q,    ovf_d;
    logic                   udf_q,    udf_d;

    logic rd_acc;
    logic wr_acc;

    // Flags are decoded from the registered count
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_empty = (count_q <= AEMPTY_C);
    assign almost_full  = (count_q >= AFULL_C);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // A read frees a slot in the same edge, so a full FIFO still takes a write
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Clear wins over a same-cycle error event
        if (clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end else begin
            if (wr_en & ~wr_acc) ovf_d = 1'b1;
            if (rd_en & ~rd_acc) udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
    end

`ifdef FIFO_FWFT_EN
    // Head entry is only shown when it holds a written word
    assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign rd_valid = ~empty;
`else
    logic [FIFO_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    // Head is captured before any same-edge write into the reused slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) rd_data_q <= mem_q[rd_ptr_q];
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed self-checking bench for fifo_sync_param (registered-read build),
// configured with depth 4, width 8, almost-full at 3, almost-empty at 1.
module tb_fifo_sync_param;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;
    logic       clr_err;

    int checks = 0;
    int errors = 0;

    fifo_sync_param #(
        .N_ADDR_BITS  (2),
        .FIFO_WIDTH   (8),
        .AFULL_THRESH (3),
        .AEMPTY_THRESH(1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .clr_err     (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and sample 1 ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [7:0] d, input logic r);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
    endtask

    initial begin : stim
        logic [7:0] q[$];
        logic [7:0] exp_word;
        logic       m_rd_acc;
        logic       m_wr_acc;
        int         written;
        logic [7:0] next_word;

        reset   = 1'b1;
        clr_err = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        step();
        step();

        chk("rst_count",    32'(count), 32'd0);
        chk("rst_empty",    32'(empty), 32'd1);
        chk("rst_full",     32'(full), 32'd0);
        chk("rst_aempty",   32'(almost_empty), 32'd1);
        chk("rst_afull",    32'(almost_full), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data",  32'(rd_data), 32'd0);
        chk("rst_ovf",      32'(overflow), 32'd0);
        chk("rst_udf",      32'(underflow), 32'd0);

        reset = 1'b0;

        // Fill: flags track count
        drive(1'b1, 8'h11, 1'b0); step();
        chk("fill1_count", 32'(count), 32'd1);
        chk("fill1_ae",    32'(almost_empty), 32'd1);
        chk("fill1_empty", 32'(empty), 32'd0);
        drive(1'b1, 8'h22, 1'b0); step();
        chk("fill2_count", 32'(count), 32'd2);
        chk("fill2_ae",    32'(almost_empty), 32'd0);
        chk("fill2_af",    32'(almost_full), 32'd0);
        drive(1'b1, 8'h33, 1'b0); step();
        chk("fill3_count", 32'(count), 32'd3);
        chk("fill3_af",    32'(almost_full), 32'd1);
        chk("fill3_full",  32'(full), 32'd0);
        drive(1'b1, 8'h44, 1'b0); step();
        chk("fill4_count", 32'(count), 32'd4);
        chk("fill4_full",  32'(full), 32'd1);

        // Write to full is dropped
        drive(1'b1, 8'h55, 1'b0); step();
        chk("ovf_set",   32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        drive(1'b0, 8'h00, 1'b0); clr_err = 1'b1; step();
        clr_err = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);

        // Drain in order
        drive(1'b0, 8'h00, 1'b1); step();
        chk("rd1_data", 32'(rd_data), 32'h11); chk("rd1_valid", 32'(rd_valid), 32'd1);
        step();
        chk("rd2_data", 32'(rd_data), 32'h22); chk("rd2_valid", 32'(rd_valid), 32'd1);
        step();
        chk("rd3_data", 32'(rd_data), 32'h33);
        step();
        chk("rd4_data",  32'(rd_data), 32'h44);
        chk("rd4_empty", 32'(empty), 32'd1);
        chk("rd4_count", 32'(count), 32'd0);
        step();
        chk("rd5_udf",   32'(underflow), 32'd1);
        chk("rd5_valid", 32'(rd_valid), 32'd0);
        chk("rd5_hold",  32'(rd_data), 32'h44);
        drive(1'b0, 8'h00, 1'b0); clr_err = 1'b1; step();
        clr_err = 1'b0;
        chk("udf_clr", 32'(underflow), 32'd0);

        // Full with simultaneous write+read reuses the popped slot
        drive(1'b1, 8'h11, 1'b0); step();
        drive(1'b1, 8'h22, 1'b0); step();
        drive(1'b1, 8'h33, 1'b0); step();
        drive(1'b1, 8'h44, 1'b0); step();
        drive(1'b1, 8'hAA, 1'b1); step();
        chk("fwr_data",  32'(rd_data), 32'h11);
        chk("fwr_valid", 32'(rd_valid), 32'd1);
        chk("fwr_count", 32'(count), 32'd4);
        chk("fwr_ovf",   32'(overflow), 32'd0);
        drive(1'b0, 8'h00, 1'b1); step();
        chk("fwr_rd2", 32'(rd_data), 32'h22);
        step();
        chk("fwr_rd3", 32'(rd_data), 32'h33);
        step();
        chk("fwr_rd4", 32'(rd_data), 32'h44);
        step();
        chk("fwr_rd5", 32'(rd_data), 32'hAA);
        chk("fwr_empty", 32'(empty), 32'd1);

        // Empty with simultaneous write+read: only the write lands
        drive(1'b1, 8'h77, 1'b1); step();
        chk("ewr_udf",   32'(underflow), 32'd1);
        chk("ewr_count", 32'(count), 32'd1);
        chk("ewr_valid", 32'(rd_valid), 32'd0);
        drive(1'b0, 8'h00, 1'b1); clr_err = 1'b1; step();
        clr_err = 1'b0;
        chk("ewr_rd_data",  32'(rd_data), 32'h77);
        chk("ewr_rd_valid", 32'(rd_valid), 32'd1);
        chk("ewr_udf_clr",  32'(underflow), 32'd0);
        drive(1'b0, 8'h00, 1'b0); step();
        chk("idle_valid_drop", 32'(rd_valid), 32'd0);

        // Interleaved 3 writes / 2 reads against a queue model, crossing wrap
        written   = 0;
        next_word = 8'hC0;
        for (int it = 0; it < 6; it++) begin
            for (int ph = 0; ph < 5; ph++) begin
                logic w, r;
                w = (ph < 3) && (written < 10) && (q.size() < 4);
                r = (ph >= 3);
                drive(w, next_word, r);
                m_rd_acc = r && (q.size() > 0);
                m_wr_acc = w && ((q.size() < 4) || m_rd_acc);
                exp_word = 8'h00;
                if (m_rd_acc) exp_word = q.pop_front();
                if (m_wr_acc) begin
                    q.push_back(next_word);
                    next_word = next_word + 8'h01;
                    written++;
                end
                step();
                chk("il_valid", 32'(rd_valid), 32'(m_rd_acc));
                if (m_rd_acc) chk("il_data", 32'(rd_data), 32'(exp_word));
                chk("il_count", 32'(count), 32'(q.size()));
            end
        end
        chk("il_written", 32'(written), 32'd10);
        chk("il_ovf", 32'(overflow), 32'd0);

        // Reset mid-operation with entries present
        drive(1'b1, 8'hE1, 1'b0); step();
        drive(1'b1, 8'hE2, 1'b0); step();
        drive(1'b0, 8'h00, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("mrst_count", 32'(count), 32'd0);
        chk("mrst_empty", 32'(empty), 32'd1);
        chk("mrst_valid", 32'(rd_valid), 32'd0);
        step();
        reset = 1'b0;
        q.delete();
        drive(1'b0, 8'h00, 1'b1); step();
        chk("mrst_rd1_valid", 32'(rd_valid), 32'd0);
        step();
        chk("mrst_rd2_valid", 32'(rd_valid), 32'd0);
        chk("mrst_udf", 32'(underflow), 32'd1);
        drive(1'b1, 8'h99, 1'b0); step();
        chk("mrst_wr_count", 32'(count), 32'd1);
        drive(1'b0, 8'h00, 1'b1); step();
        chk("mrst_new_data",  32'(rd_data), 32'h99);
        chk("mrst_new_valid", 32'(rd_valid), 32'd1);
        drive(1'b0, 8'h00, 1'b0); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
